tt_io_harness: RTL and testbench

TT_IO_HARNESS -- requirements
Module: tt_io_harness

---
 rtl/tt_harness_pkg.sv | 17 +
 rtl/tt_harness_fifo.sv | 44 ++++
 rtl/tt_io_harness.sv | 138 +++++++++++++
 tb/tb_tt_io_harness.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_harness_pkg.sv
// Shared FSM state type and default sizing constants for the tt_io_harness block.
package tt_harness_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CH_DEF     = 2;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned MISMATCH_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/tt_harness_fifo.sv
// Show-ahead synchronous FIFO; an extra pointer bit separates full from empty.
module tt_harness_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q, rd_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head reads as zero while empty so reset leaves a clean output
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tt_io_harness.sv
// Stimulus/capture harness: apply queued vectors to a DUT, settle, capture responses.
// Define HARNESS_COMPARE_EN to add per-vector expected values and a saturating mismatch counter.
module tt_io_harness
  import tt_harness_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned CH     = CH_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned VEC_W  = CH * DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [VEC_W-1:0]      s_data,
`ifdef HARNESS_COMPARE_EN
  input  logic [VEC_W-1:0]      s_expect,
  output logic [MISMATCH_W-1:0] mismatch_cnt,
`endif
  input  logic [WAIT_W-1:0]     wait_cycles,
  output logic [VEC_W-1:0]      dut_in,
  input  logic [VEC_W-1:0]      dut_out,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [VEC_W-1:0]      c_data,
  output logic                  busy
);

`ifdef HARNESS_COMPARE_EN
  localparam int unsigned STIM_W = 2 * VEC_W;
`else
  localparam int unsigned STIM_W = VEC_W;
`endif

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]    dut_in_q, dut_in_d;
  logic [STIM_W-1:0]   stim_wdata, stim_rdata;
  logic                stim_full, stim_empty, cap_full, cap_empty;
  logic                stim_pop, cap_push;
`ifdef HARNESS_COMPARE_EN
  logic [VEC_W-1:0]      exp_q, exp_d;
  logic [MISMATCH_W-1:0] mism_q, mism_d;

  assign stim_wdata   = {s_expect, s_data};
  assign mismatch_cnt = mism_q;
`else
  assign stim_wdata   = s_data;
`endif

  tt_harness_fifo #(.W(STIM_W), .DEPTH(DEPTH)) u_stim_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid),
    .data_i  (stim_wdata),
    .pop_i   (stim_pop),
    .data_o  (stim_rdata),
    .full_o  (stim_full),
    .empty_o (stim_empty)
  );

  tt_harness_fifo #(.W(VEC_W), .DEPTH(DEPTH)) u_cap_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap_push),
    .data_i  (dut_out),
    .pop_i   (c_ready),
    .data_o  (c_data),
    .full_o  (cap_full),
    .empty_o (cap_empty)
  );

  assign s_ready = !stim_full;
  assign c_valid = !cap_empty;
  assign busy    = (state_q != ST_IDLE) || !stim_empty;
  assign dut_in  = dut_in_q;

  // ena only gates new starts; a vector already past IDLE always runs to CAPTURE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dut_in_d = dut_in_q;
    stim_pop = 1'b0;
    cap_push = 1'b0;
`ifdef HARNESS_COMPARE_EN
    exp_d    = exp_q;
    mism_d   = mism_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ena && !stim_empty && !cap_full) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        stim_pop = 1'b1;
        dut_in_d = stim_rdata[VEC_W-1:0];
        cnt_d    = wait_cycles;
`ifdef HARNESS_COMPARE_EN
        exp_d    = stim_rdata[STIM_W-1:VEC_W];
`endif
        state_d  = (wait_cycles != '0) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q <= WAIT_W'(1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cap_push = 1'b1;
`ifdef HARNESS_COMPARE_EN
        if ((dut_out != exp_q) && (mism_q != '1)) mism_d = mism_q + MISMATCH_W'(1);
`endif
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dut_in_q <= '0;
`ifdef HARNESS_COMPARE_EN
      exp_q    <= '0;
      mism_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dut_in_q <= dut_in_d;
`ifdef HARNESS_COMPARE_EN
      exp_q    <= exp_d;
      mism_q   <= mism_d;
`endif
    end
  end

endmodule

// File: tb/tb_tt_io_harness.sv
// Scoreboard bench for tt_io_harness; the stand-in DUT byte-swaps its input vector.
module tb_tt_io_harness;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CH     = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned VEC_W  = 16;

  localparam logic [15:0] VEC_T [9] = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505,
                                        16'h6606, 16'h7707, 16'h8808, 16'h9909};
  localparam logic [15:0] EXP_T [9] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555,
                                        16'h0666, 16'h0777, 16'h0888, 16'h0999};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b0;
  logic             s_valid = 1'b0;
  logic             c_ready = 1'b0;
  logic [VEC_W-1:0] s_data = '0;
  logic [3:0]       wait_cycles = '0;
  logic             s_ready, c_valid, busy;
  logic [VEC_W-1:0] dut_in, dut_out, c_data;
  logic [VEC_W-1:0] exp_bias = '0;
`ifdef HARNESS_COMPARE_EN
  logic [VEC_W-1:0] s_expect = '0;
  logic [7:0]       mismatch_cnt;
`endif

  int               n_pass = 0;
  int               n_total = 0;
  int               cyc = 0;
  logic [VEC_W-1:0] sb_q [$];
  int               apply_q [$];
  int               cap_q [$];
  logic [VEC_W-1:0] last_dut_in = '0;
  bit               acc;
  int               n_acc;

  always #5 clk = ~clk;
  assign dut_out = {dut_in[7:0], dut_in[15:8]};

  tt_io_harness #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
`ifdef HARNESS_COMPARE_EN
    .s_expect     (s_expect),
    .mismatch_cnt (mismatch_cnt),
`endif
    .wait_cycles  (wait_cycles),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .c_valid      (c_valid),
    .c_ready      (c_ready),
    .c_data       (c_data),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard on each host pop and logs apply/capture cycles
  always @(negedge clk) begin
    if (!rst && c_valid && c_ready) begin
      cap_q.push_back(cyc);
      if (sb_q.size() == 0) check("capture_unexpected", 32'(c_data), 32'hFFFF_FFFF);
      else check("capture_data", 32'(c_data), 32'(sb_q.pop_front()));
    end
    if (dut_in !== last_dut_in) begin
      apply_q.push_back(cyc);
      last_dut_in = dut_in;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v, input logic [15:0] e, output bit ok);
    s_valid = 1'b1;
    s_data  = v;
`ifdef HARNESS_COMPARE_EN
    s_expect = e ^ exp_bias;
`endif
    ok = s_ready;
    if (ok) sb_q.push_back(e);
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic push_retry(input logic [15:0] v, input logic [15:0] e, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) push(v, e, ok);
  endtask

  task automatic wait_quiet(input int n);
    for (int k = 0; k < n && (busy || c_valid); k++) step(1);
  endtask

  task automatic clear_logs();
    apply_q.delete();
    cap_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut_in"}, 32'(dut_in), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_c_valid"}, 32'(c_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_c_data"}, 32'(c_data), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then a single zero-wait vector
    #1;
    check_reset_outputs("rst");
    step(2);
    rst = 1'b0;
    step(1);
    clear_logs();
    ena = 1'b1; c_ready = 1'b1; wait_cycles = 4'd0;
    push(16'h1234, 16'h3412, acc);
    check("t1_accept", 32'(acc), 32'd1);
    wait_quiet(20);
    check("t1_quiet", 32'(busy), 32'd0);
    check("t1_dut_in", 32'(dut_in), 32'h1234);
    check("t1_napply", 32'(apply_q.size()), 32'd1);
    check("t1_ncap", 32'(cap_q.size()), 32'd1);
    if (apply_q.size() > 0 && cap_q.size() > 0)
      check("t1_latency", 32'(cap_q[0] - apply_q[0]), 32'd1);

    // Fill stimulus FIFO with ena low, reject a 9th, then drain with W=1
    clear_logs();
    ena = 1'b0; wait_cycles = 4'd1; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      push(VEC_T[i], EXP_T[i], acc);
      n_acc += int'(acc);
    end
    check("t2_accepted", 32'(n_acc), 32'd8);
    check("t2_s_ready_full", 32'(s_ready), 32'd0);
    check("t2_busy_queued", 32'(busy), 32'd1);
    push(VEC_T[8], EXP_T[8], acc);
    check("t2_ninth_rejected", 32'(acc), 32'd0);
    ena = 1'b1;
    wait_quiet(100);
    check("t2_quiet", 32'(busy), 32'd0);
    check("t2_napply", 32'(apply_q.size()), 32'd8);
    for (int i = 1; i < apply_q.size(); i++)
      check("t2_spacing", 32'(apply_q[i] - apply_q[i-1]), 32'd4);
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Capture FIFO backpressure: 9 vectors, host not popping
    clear_logs();
    wait_cycles = 4'd0; c_ready = 1'b0; n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      push_retry(VEC_T[i], EXP_T[i], acc);
      n_acc += int'(acc);
    end
    check("t3_accepted", 32'(n_acc), 32'd9);
    step(40);
    check("t3_busy_stall", 32'(busy), 32'd1);
    check("t3_c_valid", 32'(c_valid), 32'd1);
    check("t3_napply", 32'(apply_q.size()), 32'd8);
    check("t3_dut_in_8th", 32'(dut_in), 32'(VEC_T[7]));
    c_ready = 1'b1;
    step(1);
    c_ready = 1'b0;
    step(10);
    check("t3_dut_in_9th", 32'(dut_in), 32'(VEC_T[8]));
    check("t3_idle", 32'(busy), 32'd0);
    c_ready = 1'b1;
    wait_quiet(50);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // wait_cycles changed while a vector is in WAIT
    clear_logs();
    wait_cycles = 4'd5;
    push(16'hABCD, 16'hCDAB, acc);
    for (int k = 0; k < 50 && apply_q.size() == 0; k++) step(1);
    step(1);
    wait_cycles = 4'd2;
    push(16'h0F0E, 16'h0E0F, acc);
    wait_quiet(60);
    check("t4_napply", 32'(apply_q.size()), 32'd2);
    check("t4_ncap", 32'(cap_q.size()), 32'd2);
    if (apply_q.size() >= 2 && cap_q.size() >= 2) begin
      check("t4_latency_a", 32'(cap_q[0] - apply_q[0]), 32'd6);
      check("t4_latency_b", 32'(cap_q[1] - apply_q[1]), 32'd3);
      check("t4_spacing", 32'(apply_q[1] - apply_q[0]), 32'd8);
    end

    // Reset during WAIT with three vectors still queued
    clear_logs();
    ena = 1'b0; wait_cycles = 4'd7;
    for (int i = 0; i < 4; i++) push(VEC_T[i], EXP_T[i], acc);
    ena = 1'b1;
    for (int k = 0; k < 50 && apply_q.size() == 0; k++) step(1);
    step(2);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    step(1);
    sb_q.delete();
    rst = 1'b0;
    step(1);
    clear_logs();
    step(40);
    check("t5_ncap", 32'(cap_q.size()), 32'd0);
    check("t5_napply", 32'(apply_q.size()), 32'd0);
    check("t5_c_valid", 32'(c_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);

`ifdef HARNESS_COMPARE_EN
    // Mismatch counter: matching vectors leave it alone, then saturation
    wait_cycles = 4'd0;
    check("t6_reset", 32'(mismatch_cnt), 32'd0);
    for (int i = 0; i < 3; i++) push_retry(VEC_T[i], EXP_T[i], acc);
    wait_quiet(50);
    check("t6_match", 32'(mismatch_cnt), 32'd0);
    exp_bias = 16'h8000;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      v = 16'(i);
      push_retry(v, {v[7:0], v[15:8]}, acc);
    end
    wait_quiet(200);
    check("t6_saturate", 32'(mismatch_cnt), 32'd255);
    exp_bias = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
